// File: rtl/mode6_sub_ctrl_pkg.sv
// Shared types and constants for the mode-6 subtract sequencer.
// Supplies fallback values for the datapath width defines when the surrounding build has none.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif
`ifndef EXPONENT
`define EXPONENT 5
`endif

package mode6_sub_ctrl_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // A new read may issue only if the result still has a guaranteed FIFO slot when it lands.
    function automatic logic credit_ok(input logic [1:0]  count,
                                       input logic        inflight,
                                       input logic        pop,
                                       input int unsigned depth);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(depth);
    endfunction

endpackage

// File: rtl/mode6_sub_ctrl_fifo.sv
// Two-entry output buffer with a registered head; push and pop may coincide.
module mode6_sub_ctrl_fifo #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop_eff;

    assign pop_eff = pop && (count_q != 2'd0);

    // Next-state for the two slots and the occupancy count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop_eff})
            2'b10: begin
                if (count_q == 2'd0) head_d = data_in;
                else                 tail_d = data_in;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = data_in;
                end else begin
                    head_d = tail_q;
                    tail_d = data_in;
                end
            end
            default: ;
        endcase
    end

    // Slot and count registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/mode6_sub_ctrl.sv
// Sequencer for the 4-lane mode-6 subtract stage: z_i = a_i - B over num_vec words.
// Optional MODE6_SUB_CTRL_STALL_CNT_EN adds a saturating write-stall counter output.
module mode6_sub_ctrl
    import mode6_sub_ctrl_pkg::*;
#(
    parameter int unsigned DW         = `DATAWIDTH,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     num_vec,
    input  logic [ADDR_W-1:0]     rd_base,
    input  logic [ADDR_W-1:0]     wr_base,
    input  logic [DW-1:0]         b_val,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [LANES*DW-1:0]   rd_data,
    output logic [LANES*DW-1:0]   sub_a,
    output logic [DW-1:0]         sub_b,
    input  logic [LANES*DW-1:0]   sub_z,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [LANES*DW-1:0]   wr_data,
    input  logic                  wr_ready,
    output logic                  busy,
    output logic                  done
`ifdef MODE6_SUB_CTRL_STALL_CNT_EN
    ,
    output logic [ADDR_W+3:0]     stall_cnt
`endif
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   num_vec_q, num_vec_d;
    logic [ADDR_W-1:0]   rd_base_q, rd_base_d;
    logic [ADDR_W-1:0]   wr_base_q, wr_base_d;
    logic [DW-1:0]       b_q, b_d;
    logic [ADDR_W-1:0]   issued_q, issued_d;
    logic [ADDR_W-1:0]   written_q, written_d;
    logic                inflight_q, inflight_d;

    logic [ADDR_W-1:0]   issued_inc;
    logic                accept, issue, pop;
    logic [1:0]          fifo_count;

    assign issued_inc = issued_q + 1'b1;
    assign pop        = wr_en & wr_ready;

    // FSM next-state plus start-accept and read-issue decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (num_vec == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (credit_ok(fifo_count, inflight_q, pop, FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (issued_inc == num_vec_q) state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave as the last word is accepted so done lands right after it.
                if (!inflight_q && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop))) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand latches and word counters.
    always_comb begin
        num_vec_d  = num_vec_q;
        rd_base_d  = rd_base_q;
        wr_base_d  = wr_base_q;
        b_d        = b_q;
        issued_d   = issued_q;
        written_d  = written_q;
        inflight_d = issue;
        if (accept) begin
            num_vec_d = num_vec;
            rd_base_d = rd_base;
            wr_base_d = wr_base;
            b_d       = b_val;
            issued_d  = '0;
            written_d = '0;
        end else begin
            if (issue) issued_d = issued_inc;
            if (pop)   written_d = written_q + 1'b1;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            num_vec_q  <= '0;
            rd_base_q  <= '0;
            wr_base_q  <= '0;
            b_q        <= '0;
            issued_q   <= '0;
            written_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_vec_q  <= num_vec_d;
            rd_base_q  <= rd_base_d;
            wr_base_q  <= wr_base_d;
            b_q        <= b_d;
            issued_q   <= issued_d;
            written_q  <= written_d;
            inflight_q <= inflight_d;
        end
    end

    // Subtractor result arrives the cycle after the read strobe.
    mode6_sub_ctrl_fifo #(
        .W (LANES * DW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (inflight_q),
        .data_in (sub_z),
        .pop     (pop),
        .head    (wr_data),
        .count   (fifo_count)
    );

    assign rd_en   = issue;
    assign rd_addr = rd_base_q + issued_q;
    assign sub_a   = rd_data;
    assign sub_b   = b_q;
    assign wr_en   = (fifo_count != 2'd0);
    assign wr_addr = wr_base_q + written_q;
    assign busy    = (state_q == StRun) || (state_q == StDrain);
    assign done    = (state_q == StDone);

`ifdef MODE6_SUB_CTRL_STALL_CNT_EN
    logic [ADDR_W+3:0] stall_q, stall_d;

    // Saturating count of cycles a write was offered but not accepted.
    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if (wr_en && !wr_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mode6_sub_ctrl.sv
// Self-checking bench for mode6_sub_ctrl: scratchpad and subtractor models plus a
// per-job expectation queue built from the job parameters.
module tb_mode6_sub_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;
    localparam int unsigned WW = 4 * DW;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] num_vec, rd_base, wr_base;
    logic [DW-1:0] b_val;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [WW-1:0] rd_data, sub_a, sub_z, wr_data;
    logic [DW-1:0] sub_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_ready, busy, done;
`ifdef MODE6_SUB_CTRL_STALL_CNT_EN
    logic [AW+3:0] stall_cnt;
`endif

    int total;
    int bad;

    logic [WW-1:0] mem [1024];

    mode6_sub_ctrl #(
        .DW         (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_vec   (num_vec),
        .rd_base   (rd_base),
        .wr_base   (wr_base),
        .b_val     (b_val),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .sub_a     (sub_a),
        .sub_b     (sub_b),
        .sub_z     (sub_z),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done)
`ifdef MODE6_SUB_CTRL_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scratchpad: fixed one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Integer stand-in for the external lane subtractors.
    always_comb begin
        sub_z = '0;
        for (int i = 0; i < 4; i++) sub_z[i*DW +: DW] = sub_a[i*DW +: DW] - sub_b;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] sub_word(input logic [WW-1:0] a, input logic [DW-1:0] b);
        logic [WW-1:0] r;
        for (int i = 0; i < 4; i++) r[i*DW +: DW] = a[i*DW +: DW] - b;
        return r;
    endfunction

    // mode 0: always ready; 1: not ready in cycles 4..9; 2: random ~60% ready.
    function automatic logic ready_at(input int mode, input int c);
        if (mode == 1) return !(c >= 4 && c <= 9);
        if (mode == 2) return ($urandom_range(0, 99) < 60);
        return 1'b1;
    endfunction

    // Caller must be just after a rising edge; returns in the same phase.
    task automatic run_job(input int n, input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                           input logic [DW-1:0] b, input int mode, input int poke_cyc,
                           input int exp_stall);
        logic [AW-1:0] exp_addr[$];
        logic [WW-1:0] exp_data[$];
        logic [AW-1:0] ra;
        int cyc, reads, writes, max_out, first_wr, done_cyc, done_cnt, stalls;

        for (int k = 0; k < n; k++) begin
            ra = rb + AW'(k);
            exp_addr.push_back(wb + AW'(k));
            exp_data.push_back(sub_word(mem[ra], b));
        end

        start    = 1'b1;
        num_vec  = AW'(n);
        rd_base  = rb;
        wr_base  = wb;
        b_val    = b;
        wr_ready = ready_at(mode, 0);
        cyc = 0; reads = 0; writes = 0; max_out = 0;
        first_wr = -1; done_cyc = -1; done_cnt = 0; stalls = 0;

        while (cyc < 40 * (n + 2) + 50) begin
            @(negedge clk);
            if (rd_en) begin
                ra = rb + AW'(reads);
                check_eq("rd_addr", 64'(rd_addr), 64'(ra));
                reads++;
            end
            if (cyc == 1 && n > 0) check_eq("busy_run", 64'(busy), 64'(1));
            if (cyc == 2 && n > 0) check_eq("sub_b_held", 64'(sub_b), 64'(b));
            if (wr_en && first_wr < 0) first_wr = cyc;
            if (wr_en && !wr_ready) stalls++;
            if (wr_en && wr_ready) begin
                if (exp_data.size() == 0) begin
                    check_eq("extra_write", 64'(writes), 64'(n - 1));
                end else begin
                    check_eq("wr_addr", 64'(wr_addr), 64'(exp_addr.pop_front()));
                    check_eq("wr_data", wr_data, exp_data.pop_front());
                end
                writes++;
            end
            if (reads - writes > max_out) max_out = reads - writes;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                check_eq("busy_at_done", 64'(busy), 64'(0));
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(posedge clk);
            #1;
            start   = 1'b0;
            b_val   = DW'($urandom);
            num_vec = AW'($urandom);
            rd_base = AW'($urandom);
            wr_base = AW'($urandom);
            if (cyc + 1 == poke_cyc) begin
                start   = 1'b1;
                num_vec = AW'(n + 5);
            end
            wr_ready = ready_at(mode, cyc + 1);
            cyc++;
        end

        check_eq("done_count", 64'(done_cnt), 64'(1));
        check_eq("reads", 64'(reads), 64'(n));
        check_eq("writes", 64'(writes), 64'(n));
        check_eq("max_ahead_le2", 64'(max_out <= 2), 64'(1));
        check_eq("first_wr_cycle", 64'(first_wr), (n > 0) ? 64'(3) : 64'(-1));
        if (mode == 0) check_eq("done_cycle", 64'(done_cyc), (n > 0) ? 64'(n + 3) : 64'(1));
        if (exp_stall >= 0) check_eq("stall_cycles", 64'(stalls), 64'(exp_stall));
`ifdef MODE6_SUB_CTRL_STALL_CNT_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
        check_eq("sub_b_after", 64'(sub_b), 64'(b));

        @(posedge clk);
        #1;
        start    = 1'b0;
        wr_ready = 1'b1;
    endtask

    initial begin
        int seen;
        logic [AW-1:0] rb;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};

        reset    = 1'b0;
        start    = 1'b0;
        num_vec  = '0;
        rd_base  = '0;
        wr_base  = '0;
        b_val    = '0;
        wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rd_en", 64'(rd_en), 64'(0));
        check_eq("rst_wr_en", 64'(wr_en), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_rd_addr", 64'(rd_addr), 64'(0));
        check_eq("rst_wr_addr", 64'(wr_addr), 64'(0));
        check_eq("rst_sub_b", 64'(sub_b), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single word, then streaming, backpressure, zero-length and address wrap.
        mem[5] = {4{16'h4000}};
        run_job(1, 10'd5, 10'd100, 16'h3C00, 0, -1, -1);
        run_job(8, 10'd40, 10'd200, 16'h0000, 0, -1, 0);
        run_job(6, 10'd60, 10'd300, 16'h1111, 1, -1, 6);
        run_job(0, 10'd7, 10'd9, 16'h2222, 0, -1, 0);
        run_job(4, 10'd1022, 10'd1021, 16'h0101, 0, -1, 0);

        // Reset in the middle of a 10-word run.
        start    = 1'b1;
        num_vec  = 10'd10;
        rd_base  = 10'd500;
        wr_base  = 10'd600;
        b_val    = 16'h1234;
        wr_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("mid_busy", 64'(busy), 64'(1));
        check_eq("mid_wr_en", 64'(wr_en), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", 64'(busy), 64'(0));
        check_eq("post_rst_wr_en", 64'(wr_en), 64'(0));
        check_eq("post_rst_rd_en", 64'(rd_en), 64'(0));
        check_eq("post_rst_rd_addr", 64'(rd_addr), 64'(0));
        check_eq("post_rst_sub_b", 64'(sub_b), 64'(0));
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_en || rd_en || done || busy) seen++;
        end
        check_eq("idle_after_reset", 64'(seen), 64'(0));
        @(posedge clk);
        #1;
        run_job(5, 10'd800, 10'd900, 16'h0F0F, 0, -1, 0);

        // Start pulses while busy and on the done cycle are ignored.
        run_job(8, 10'd100, 10'd110, 16'h00AA, 0, 3, 0);
        run_job(5, 10'd120, 10'd130, 16'h5555, 0, 8, 0);

        // Random jobs with random backpressure.
        for (int j = 0; j < 10; j++) begin
            rb = AW'($urandom);
            if (j % 3 == 0) rb = 10'd1020;
            run_job(int'($urandom_range(1, 24)), rb, AW'($urandom), DW'($urandom),
                    (j % 2 == 0) ? 2 : 0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mode6_sub_ctrl.md
Name: mode6_sub_ctrl

Overview:
- Sequencer for the 4-lane mode-6 subtract stage of the softmax datapath.
- On start, latches one scalar operand B (running max or log-sum-exp).
- Streams num_vec 4-lane words from the input scratchpad through the 4 external subtractors (z_i = a_i - B) and writes results to the output scratchpad.
- Fixed-latency read port, backpressured write port, 1 word/cycle sustained.

Parameters:
- DW, `DATAWIDTH (16): lane width.
- ADDR_W, 10: scratchpad address width, in words.
- FIFO_DEPTH, 2: output buffer depth. Fixed at 2; other values are not supported.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle launch pulse; ignored while busy.
- num_vec  in  ADDR_W  word count; sampled with start.
- rd_base  in  ADDR_W  first read address; sampled with start.
- wr_base  in  ADDR_W  first write address; sampled with start.
- b_val  in  DW  subtrahend; sampled with start.
- rd_en  out  1  read strobe.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  4*DW  read data; valid exactly 1 cycle after rd_en. Lane i = bits [i*DW +: DW].
- sub_a  out  4*DW  to subtractor a_inp0..3; combinational pass of rd_data.
- sub_b  out  DW  to subtractor b_inp; latched B.
- sub_z  in  4*DW  from subtractor outp0..3.
- wr_en  out  1  write valid.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  4*DW  write data.
- wr_ready  in  1  write accept; transfer occurs when wr_en & wr_ready.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0 at a clk edge) forces:
  - state IDLE; FIFO emptied; in-flight flag cleared.
  - rd_en=0, wr_en=0, busy=0, done=0.
  - rd_addr=0, wr_addr=0, sub_b=0.
- Reset mid-operation abandons all pending words; none are written after reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches num_vec, bases and b_val.
  - num_vec=0 -> DONE; otherwise -> RUN.
- RUN:
  - Issue a read (rd_en=1, rd_addr=rd_base+issued) when credits allow: fifo_count + inflight - pop < 2, where pop = wr_en & wr_ready this cycle.
  - Each issue increments issued. When issued reaches num_vec -> DRAIN.
- Pipeline:
  - inflight is a 1-bit register set by rd_en.
  - In the cycle inflight=1, sub_z is pushed into the FIFO (subtractor is combinational).
- DRAIN: waits until inflight=0 and the FIFO is empty, then -> DONE.
- DONE: done=1 for one cycle, then -> IDLE. busy falls in the same cycle done rises.
- Output: wr_en = FIFO non-empty; wr_data = FIFO head (registered).
  - wr_addr = wr_base + written; written increments on each handshake.
- Latency: start at cycle 0 -> rd_en at cycle 1 -> push at cycle 2 -> wr_en at cycle 3.
- Throughput: with wr_ready held high, one write per cycle. N words complete with done at cycle N+3.
- Backpressure: while wr_ready=0, at most 2 words are held and issue stops. No data is lost or duplicated.
- Address arithmetic wraps modulo 2^ADDR_W.
- start while busy is ignored. start asserted in the same cycle as done is ignored; it is accepted from IDLE only.
- B is held constant for the whole run; a change on b_val mid-run has no effect.
- sub_b is driven from the latched register at all times, including IDLE.

Optional Feature:
- Macro MODE6_SUB_CTRL_STALL_CNT_EN.
- Defined: adds output stall_cnt [ADDR_W+3:0].
  - Cleared when a start is accepted.
  - Increments each cycle wr_en=1 and wr_ready=0.
  - Saturates at all-ones; holds its value after done.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package/defines:
  - FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3).
  - LANES=4 constant.
  - Reuse existing `DATAWIDTH/`MANTISSA/`EXPONENT defines.
- One sub-module: mode6_sub_ctrl_fifo.
  - 2-entry, 4*DW wide, registered head.
  - Ports: push/data_in, pop, head, count.
  - Simultaneous push+pop is allowed at count 1 or 2.
- The mode6_sub datapath stays outside the controller and connects via sub_a/sub_b/sub_z.

Test Plan:
- Single word: reset 2 cycles; start with num_vec=1, b_val=16'h3C00 (1.0); memory lanes 16'h4000 (2.0) each.
  -> wr_en at cycle 3, wr_data lanes 16'h3C00, wr_addr=wr_base, done at cycle 4.
- Streaming: num_vec=8, wr_ready=1, b_val=16'h0000.
  -> 8 consecutive writes with data equal to input, addresses wr_base..wr_base+7, done at cycle 11.
- Backpressure: num_vec=6; wr_ready low for cycles 4-9.
  -> at most 2 reads issued ahead; writes resume in order with no gaps/duplicates; all 6 written correctly. stall_cnt=6 when MODE6_SUB_CTRL_STALL_CNT_EN is defined.
- Zero / wrap: num_vec=0 -> done at cycle 1, no rd_en/wr_en. Then rd_base=1022, ADDR_W=10, num_vec=4 -> rd_addr 1022, 1023, 0, 1.
- Reset mid-run: num_vec=10; reset=0 at cycle 5 for 1 cycle.
  -> next cycle busy=0, wr_en=0, rd_en=0; a new start runs cleanly from IDLE.
- Ignored start: start pulsed at cycle 3 of an active run with different b_val.
  -> run unaffected; no second done.
